// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if -- request/read/result bundle of the sequential multiply/divide unit.
//   start, op, rs, rt : operation request strobe, opcode and operands (master -> slave)
//   rd_req, rd_sel    : MFHI/MFLO read request, 0 = LO, 1 = HI      (master -> slave)
//   busy              : multiply/divide in progress                  (slave -> master)
//   rd_valid, rd_data : registered read response                     (slave -> master)
//   hi, lo            : architectural HI/LO registers                (slave -> master)
interface muldiv_seq_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        rd_req;
  logic        rd_sel;
  logic        busy;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs, rt, rd_req, rd_sel,
    input  busy, rd_valid, rd_data, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, rd_req, rd_sel,
    output busy, rd_valid, rd_data, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq -- sequential MIPS-style HI/LO multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle over 32 RUN cycles, followed by one FIX cycle that
// applies signs and writes HI/LO. MTHI/MTLO complete in one idle cycle.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (aborts any operation in flight)
//   bus   : muldiv_seq_if slave (request, read port, busy, HI/LO outputs)
module muldiv_seq (
  input  logic         clk,
  input  logic         reset,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_busy;

  logic [4:0]  r_cnt;
  logic [63:0] r_acc;      // mult: {partial product, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] r_opb;      // multiplicand or divisor magnitude
  logic        r_is_div;
  logic        r_neg_q;    // negate product / quotient in FIX
  logic        r_neg_r;    // negate remainder in FIX
  logic        r_div0;
  logic [31:0] r_rs;       // original dividend, returned as HI on divide by zero
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;

  logic        w_idle;
  logic        w_accept;
  logic        w_signed;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_step;
  logic [32:0] w_div_sh;
  logic [32:0] w_div_diff;
  logic [63:0] w_div_step;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_idle   = (r_state == S_IDLE);
  // op 000..011 are the multi-cycle ops; bit 0 clear means signed
  assign w_accept = w_idle && bus.start && !bus.op[2];
  assign w_signed = !bus.op[0];
  assign w_mag_a  = (w_signed && bus.rs[31]) ? (~bus.rs + 32'd1) : bus.rs;
  assign w_mag_b  = (w_signed && bus.rt[31]) ? (~bus.rt + 32'd1) : bus.rt;

  // One shift-add step: conditionally add multiplicand into the upper half,
  // then shift the whole 65-bit result right by one.
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_step = {w_mul_sum, r_acc[31:1]};

  // One restoring step: shift next dividend bit into the remainder, trial
  // subtract, keep the difference only when it did not borrow.
  assign w_div_sh   = {r_acc[63:32], r_acc[31]};
  assign w_div_diff = w_div_sh - {1'b0, r_opb};
  assign w_div_step = {(w_div_diff[32] ? w_div_sh[31:0] : w_div_diff[31:0]),
                       r_acc[30:0], ~w_div_diff[32]};

  // Sign fix-up of the magnitude result, evaluated during FIX.
  always_comb begin
    w_res_hi = r_acc[63:32];
    w_res_lo = r_acc[31:0];
    if (!r_is_div) begin
      if (r_neg_q) begin
        {w_res_hi, w_res_lo} = ~r_acc + 64'd1;
      end
    end else if (r_div0) begin
      w_res_hi = r_rs;
      w_res_lo = 32'hFFFF_FFFF;
    end else begin
      if (r_neg_q) begin
        w_res_lo = ~r_acc[31:0] + 32'd1;
      end
      if (r_neg_r) begin
        w_res_hi = ~r_acc[63:32] + 32'd1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd31) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // Datapath, HI/LO and read port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 5'd0;
      r_acc      <= 64'd0;
      r_opb      <= 32'd0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div0     <= 1'b0;
      r_rs       <= 32'd0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
    end else begin
      // Reads sample HI/LO before any update made in the same cycle.
      if (bus.rd_req && w_idle) begin
        r_rd_data  <= bus.rd_sel ? r_hi : r_lo;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc    <= {32'd0, w_mag_a};
            r_opb    <= w_mag_b;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_signed && (bus.rs[31] ^ bus.rt[31]);
            r_neg_r  <= w_signed && bus.rs[31];
            r_div0   <= (bus.rt == 32'd0);
            r_rs     <= bus.rs;
            r_cnt    <= 5'd0;
          end else if (bus.start && bus.op == 3'b100) begin
            r_hi <= bus.rs;
          end else if (bus.start && bus.op == 3'b101) begin
            r_lo <= bus.rs;
          end
        end
        S_RUN: begin
          r_acc <= r_is_div ? w_div_step : w_mul_step;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
        default: begin
          r_cnt <= 5'd0;
        end
      endcase
    end
  end

  assign bus.busy     = w_busy;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- directed bench for muldiv_seq with a cycle-level
// behavioural model (plain arithmetic results, busy countdown) and literal
// pinned expectations for the hand-computed vectors.
module tb_muldiv_seq;

  localparam int K_HI   = 0;
  localparam int K_LO   = 1;
  localparam int K_RD   = 2;
  localparam int K_RV   = 3;
  localparam int K_BUSY = 4;

  logic clk;
  logic reset;
  muldiv_seq_if bus_if();

  muldiv_seq u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // ---------------- behavioural model ----------------
  logic        m_init;
  logic [5:0]  m_cnt;     // remaining busy cycles
  logic [63:0] m_pend;    // {HI, LO} to be written when the countdown ends
  logic [31:0] m_hi, m_lo, m_rd;
  logic        m_rv;

  function automatic logic [63:0] model_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p;
    int ia, ib, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    res = 64'd0;
    case (op)
      3'b000: begin p = sa * sb; res = p; end
      3'b001: res = {32'd0, a} * {32'd0, b};
      3'b010: begin
        if (b == 32'd0)                                   res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin q = ia / ib; r = ia % ib; res = {r, q}; end
      end
      3'b011: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else            res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_init <= 1'b1;
      m_cnt  <= 6'd0;
      m_pend <= 64'd0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_rd   <= 32'd0;
      m_rv   <= 1'b0;
    end else begin
      if (bus_if.rd_req && m_cnt == 6'd0) begin
        m_rd <= bus_if.rd_sel ? m_hi : m_lo;
        m_rv <= 1'b1;
      end else begin
        m_rv <= 1'b0;
      end
      if (m_cnt != 6'd0) begin
        m_cnt <= m_cnt - 6'd1;
        if (m_cnt == 6'd1) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
        end
      end else if (bus_if.start) begin
        case (bus_if.op)
          3'b000, 3'b001, 3'b010, 3'b011: begin
            m_pend <= model_res(bus_if.op, bus_if.rs, bus_if.rt);
            m_cnt  <= 6'd33;
          end
          3'b100:  m_hi <= bus_if.rs;
          3'b101:  m_lo <= bus_if.rs;
          default: ;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  logic        pin_en;
  int          pin_kind;
  logic [31:0] pin_exp;
  string       pin_name;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init === 1'b1) begin
      chk("busy",     {31'd0, bus_if.busy},     {31'd0, (m_cnt != 6'd0)});
      chk("hi",       bus_if.hi,                m_hi);
      chk("lo",       bus_if.lo,                m_lo);
      chk("rd_valid", {31'd0, bus_if.rd_valid}, {31'd0, m_rv});
      chk("rd_data",  bus_if.rd_data,           m_rd);
    end
    if (pin_en) begin
      case (pin_kind)
        K_HI:    chk(pin_name, bus_if.hi,                pin_exp);
        K_LO:    chk(pin_name, bus_if.lo,                pin_exp);
        K_RD:    chk(pin_name, bus_if.rd_data,           pin_exp);
        K_RV:    chk(pin_name, {31'd0, bus_if.rd_valid}, pin_exp);
        default: chk(pin_name, {31'd0, bus_if.busy},     pin_exp);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation checked at the next falling edge (same cycle).
  task automatic pin(input string name, input int kind, input logic [31:0] exp);
    pin_name = name;
    pin_kind = kind;
    pin_exp  = exp;
    pin_en   = 1'b1;
    @(negedge clk);
    #1;
    pin_en   = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    cyc();
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.rs    = a;
    bus_if.rt    = b;
    $display("op=%0d rs=%h rt=%h", op, a, b);
    cyc();
    bus_if.start = 1'b0;
    repeat (33) cyc();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    pin_en        = 1'b0;
    pin_kind      = 0;
    pin_exp       = 32'd0;
    pin_name      = "";
    reset         = 1'b1;
    bus_if.start  = 1'b0;
    bus_if.op     = 3'b000;
    bus_if.rs     = 32'd0;
    bus_if.rt     = 32'd0;
    bus_if.rd_req = 1'b0;
    bus_if.rd_sel = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    $display("reset released");
    pin("rst_hi", K_HI, 32'd0);
    pin("rst_lo", K_LO, 32'd0);
    pin("rst_rd_valid", K_RV, 32'd0);
    pin("rst_rd_data", K_RD, 32'd0);
    pin("rst_busy", K_BUSY, 32'd0);

    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pin("multu_max_hi", K_HI, 32'hFFFF_FFFE);
    pin("multu_max_lo", K_LO, 32'h0000_0001);

    run_op(3'b000, 32'hFFFF_FFFE, 32'd3);
    pin("mult_neg_hi", K_HI, 32'hFFFF_FFFF);
    pin("mult_neg_lo", K_LO, 32'hFFFF_FFFA);

    run_op(3'b000, 32'h8000_0000, 32'h8000_0000);
    pin("mult_min_hi", K_HI, 32'h4000_0000);
    pin("mult_min_lo", K_LO, 32'h0000_0000);

    run_op(3'b010, 32'hFFFF_FFF9, 32'd2);
    pin("div_m7_2_lo", K_LO, 32'hFFFF_FFFD);
    pin("div_m7_2_hi", K_HI, 32'hFFFF_FFFF);

    run_op(3'b010, 32'd7, 32'hFFFF_FFFE);
    pin("div_7_m2_lo", K_LO, 32'hFFFF_FFFD);
    pin("div_7_m2_hi", K_HI, 32'h0000_0001);

    run_op(3'b011, 32'd100, 32'd0);
    pin("divu_by0_lo", K_LO, 32'hFFFF_FFFF);
    pin("divu_by0_hi", K_HI, 32'd100);

    run_op(3'b010, 32'hFFFF_FFFB, 32'd0);
    pin("div_by0_lo", K_LO, 32'hFFFF_FFFF);
    pin("div_by0_hi", K_HI, 32'hFFFF_FFFB);

    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    pin("div_ovf_lo", K_LO, 32'h8000_0000);
    pin("div_ovf_hi", K_HI, 32'h0000_0000);

    // MTLO with a same-cycle LO read returns the old LO
    cyc();
    bus_if.start  = 1'b1;
    bus_if.op     = 3'b101;
    bus_if.rs     = 32'h0000_1234;
    bus_if.rd_req = 1'b1;
    bus_if.rd_sel = 1'b0;
    $display("op=5 rs=%h with rd_req lo", bus_if.rs);
    cyc();
    bus_if.start = 1'b0;
    pin("mtlo_old_rd", K_RD, 32'h8000_0000);
    cyc();
    bus_if.rd_req = 1'b0;
    pin("mtlo_new_rd", K_RD, 32'h0000_1234);
    pin("mtlo_lo", K_LO, 32'h0000_1234);

    // MTHI
    cyc();
    bus_if.start = 1'b1;
    bus_if.op    = 3'b100;
    bus_if.rs    = 32'h0000_ABCD;
    $display("op=4 rs=%h", bus_if.rs);
    cyc();
    bus_if.start = 1'b0;
    pin("mthi_busy", K_BUSY, 32'd0);
    pin("mthi_hi", K_HI, 32'h0000_ABCD);

    // undefined op is a no-op
    cyc();
    bus_if.start = 1'b1;
    bus_if.op    = 3'b110;
    bus_if.rs    = 32'h5555_5555;
    $display("op=6 rs=%h", bus_if.rs);
    cyc();
    bus_if.start = 1'b0;
    pin("undef_busy", K_BUSY, 32'd0);
    pin("undef_hi", K_HI, 32'h0000_ABCD);
    pin("undef_lo", K_LO, 32'h0000_1234);

    // DIVU 10/3 with a HI read stalled behind it and an ignored restart
    cyc();
    bus_if.start = 1'b1;
    bus_if.op    = 3'b011;
    bus_if.rs    = 32'd10;
    bus_if.rt    = 32'd3;
    $display("op=3 rs=%h rt=%h with stalled rd hi", bus_if.rs, bus_if.rt);
    cyc();
    bus_if.start  = 1'b0;
    bus_if.rd_req = 1'b1;
    bus_if.rd_sel = 1'b1;
    repeat (4) cyc();
    bus_if.start = 1'b1;
    bus_if.op    = 3'b001;
    bus_if.rs    = 32'd5;
    bus_if.rt    = 32'd5;
    cyc();
    bus_if.start = 1'b0;
    repeat (28) cyc();
    pin("stall_rv_t34", K_RV, 32'd0);
    cyc();
    pin("stall_rv_t35", K_RV, 32'd1);
    pin("stall_rd", K_RD, 32'd1);
    bus_if.rd_req = 1'b0;
    pin("divu_10_3_lo", K_LO, 32'd3);

    // reset in the middle of a MULTU
    cyc();
    bus_if.start = 1'b1;
    bus_if.op    = 3'b001;
    bus_if.rs    = 32'd7;
    bus_if.rt    = 32'd9;
    $display("op=1 rs=%h rt=%h then reset", bus_if.rs, bus_if.rt);
    cyc();
    bus_if.start = 1'b0;
    repeat (9) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    pin("abort_busy", K_BUSY, 32'd0);
    pin("abort_hi", K_HI, 32'd0);
    pin("abort_lo", K_LO, 32'd0);
    repeat (30) cyc();
    pin("abort_late_hi", K_HI, 32'd0);
    pin("abort_late_lo", K_LO, 32'd0);

    cyc();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
